// File: rtl/exe_alu_unit.sv
// Execute-stage compute block: ALU-control decode, 32-bit integer ALU with
// zero/overflow flags, and branch-target adder, with registered outputs.
module exe_alu_unit #(
  parameter int WIDTH = 32  // only 32 is meaningful for this ISA
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [3:0]       alu_op,
  input  logic [5:0]       func,
  input  logic [4:0]       shamt,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic [WIDTH-1:0] pc_plus4,
  input  logic [WIDTH-1:0] ext_imm,
  output logic [4:0]       operation,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic [WIDTH-1:0] branch_addr
);

  localparam logic [4:0] OP_AND  = 5'd0;
  localparam logic [4:0] OP_OR   = 5'd1;
  localparam logic [4:0] OP_ADD  = 5'd2;
  localparam logic [4:0] OP_ADDU = 5'd3;
  localparam logic [4:0] OP_SUB  = 5'd4;
  localparam logic [4:0] OP_SUBU = 5'd5;
  localparam logic [4:0] OP_XOR  = 5'd6;
  localparam logic [4:0] OP_NOR  = 5'd7;
  localparam logic [4:0] OP_SLT  = 5'd8;
  localparam logic [4:0] OP_SLTU = 5'd9;
  localparam logic [4:0] OP_SLL  = 5'd10;
  localparam logic [4:0] OP_SRL  = 5'd11;
  localparam logic [4:0] OP_SRA  = 5'd12;
  localparam logic [4:0] OP_SLLV = 5'd13;
  localparam logic [4:0] OP_SRLV = 5'd14;
  localparam logic [4:0] OP_SRAV = 5'd15;
  localparam logic [4:0] OP_LUI  = 5'd16;
  localparam logic [4:0] OP_NOP  = 5'd31;

  logic [4:0]       w_operation;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_result;
  logic             w_overflow;
  logic             w_zero;
  logic [WIDTH-1:0] w_branch_addr;

  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_overflow;
  logic [WIDTH-1:0] r_branch_addr;

  // NOTE: every always_comb output gets a default before the case so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_operation = OP_ADDU;
    case (alu_op)
      4'b0000: begin
        w_operation = OP_NOP;
        case (func)
          6'b100000: w_operation = OP_ADD;
          6'b100001: w_operation = OP_ADDU;
          6'b100010: w_operation = OP_SUB;
          6'b100011: w_operation = OP_SUBU;
          6'b100100: w_operation = OP_AND;
          6'b100101: w_operation = OP_OR;
          6'b100110: w_operation = OP_XOR;
          6'b100111: w_operation = OP_NOR;
          6'b101010: w_operation = OP_SLT;
          6'b101011: w_operation = OP_SLTU;
          6'b000000: w_operation = OP_SLL;
          6'b000010: w_operation = OP_SRL;
          6'b000011: w_operation = OP_SRA;
          6'b000100: w_operation = OP_SLLV;
          6'b000110: w_operation = OP_SRLV;
          6'b000111: w_operation = OP_SRAV;
          default:   w_operation = OP_NOP;
        endcase
      end
      4'b0001: w_operation = OP_ADD;
      4'b0010: w_operation = OP_SUB;
      4'b0011: w_operation = OP_AND;
      4'b0100: w_operation = OP_OR;
      4'b0101: w_operation = OP_XOR;
      4'b0110: w_operation = OP_SLT;
      4'b0111: w_operation = OP_SLTU;
      4'b1000: w_operation = OP_LUI;
      default: w_operation = OP_ADDU;
    endcase
  end

  assign operation = w_operation;

  // One adder and one subtractor shared by the signed and unsigned forms.
  assign w_sum  = op1 + op2;
  assign w_diff = op1 - op2;

  always_comb begin
    w_result   = '0;
    w_overflow = 1'b0;
    case (w_operation)
      OP_AND:  w_result = op1 & op2;
      OP_OR:   w_result = op1 | op2;
      OP_ADD: begin
        w_result   = w_sum;
        w_overflow = (op1[WIDTH-1] == op2[WIDTH-1]) && (w_sum[WIDTH-1] != op1[WIDTH-1]);
      end
      OP_ADDU: w_result = w_sum;
      OP_SUB: begin
        w_result   = w_diff;
        w_overflow = (op1[WIDTH-1] != op2[WIDTH-1]) && (w_diff[WIDTH-1] != op1[WIDTH-1]);
      end
      OP_SUBU: w_result = w_diff;
      OP_XOR:  w_result = op1 ^ op2;
      OP_NOR:  w_result = ~(op1 | op2);
      OP_SLT:  w_result = {{(WIDTH-1){1'b0}}, ($signed(op1) < $signed(op2))};
      OP_SLTU: w_result = {{(WIDTH-1){1'b0}}, (op1 < op2)};
      OP_SLL:  w_result = op2 << shamt;
      OP_SRL:  w_result = op2 >> shamt;
      OP_SRA:  w_result = $signed(op2) >>> shamt;
      OP_SLLV: w_result = op2 << op1[4:0];
      OP_SRLV: w_result = op2 >> op1[4:0];
      OP_SRAV: w_result = $signed(op2) >>> op1[4:0];
      OP_LUI:  w_result = {op2[15:0], {(WIDTH-16){1'b0}}};
      default: w_result = '0;
    endcase
  end

  assign w_zero        = (w_result == '0);
  assign w_branch_addr = pc_plus4 + (ext_imm << 2);

  // NOTE: state registers use non-blocking assignment so all of them update
  // together at the edge. Reset is synchronous and takes priority over en.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_result      <= '0;
      r_zero        <= 1'b0;
      r_overflow    <= 1'b0;
      r_branch_addr <= '0;
    end else if (en) begin
      r_result      <= w_result;
      r_zero        <= w_zero;
      r_overflow    <= w_overflow;
      r_branch_addr <= w_branch_addr;
    end
  end

  assign result      = r_result;
  assign zero        = r_zero;
  assign overflow    = r_overflow;
  assign branch_addr = r_branch_addr;

endmodule

// File: tb/tb_exe_alu_unit.sv
// Self-checking bench for exe_alu_unit: directed scenarios plus a randomized
// run compared against an arithmetic reference model.
module tb_exe_alu_unit;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [3:0]  alu_op;
  logic [5:0]  func;
  logic [4:0]  shamt;
  logic [31:0] op1, op2, pc_plus4, ext_imm;
  logic [4:0]  operation;
  logic [31:0] result;
  logic        zero;
  logic        overflow;
  logic [31:0] branch_addr;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [4:0]  op;
    logic [31:0] res;
    logic        z;
    logic        ov;
    logic [31:0] br;
  } exp_t;

  exp_t exp_q;   // expected registered outputs after the latest edge

  exe_alu_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .alu_op(alu_op), .func(func),
    .shamt(shamt), .op1(op1), .op2(op2), .pc_plus4(pc_plus4),
    .ext_imm(ext_imm), .operation(operation), .result(result),
    .zero(zero), .overflow(overflow), .branch_addr(branch_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam longint MAX_S = 64'sd2147483647;
  localparam longint MIN_S = -64'sd2147483648;

  function automatic logic [4:0] ref_decode(input logic [3:0] a, input logic [5:0] f);
    if (a == 4'd0) begin
      case (f)
        6'h20: return 5'd2;   6'h21: return 5'd3;
        6'h22: return 5'd4;   6'h23: return 5'd5;
        6'h24: return 5'd0;   6'h25: return 5'd1;
        6'h26: return 5'd6;   6'h27: return 5'd7;
        6'h2A: return 5'd8;   6'h2B: return 5'd9;
        6'h00: return 5'd10;  6'h02: return 5'd11;
        6'h03: return 5'd12;  6'h04: return 5'd13;
        6'h06: return 5'd14;  6'h07: return 5'd15;
        default: return 5'd31;
      endcase
    end
    case (a)
      4'd1: return 5'd2;  4'd2: return 5'd4;  4'd3: return 5'd0;
      4'd4: return 5'd1;  4'd5: return 5'd6;  4'd6: return 5'd8;
      4'd7: return 5'd9;  4'd8: return 5'd16;
      default: return 5'd3;
    endcase
  endfunction

  // Signed ops use 64-bit arithmetic; overflow means the true sum left int range.
  function automatic exp_t ref_model(input logic [3:0] a, input logic [5:0] f,
                                     input logic [4:0] s, input logic [31:0] x,
                                     input logic [31:0] y, input logic [31:0] pc,
                                     input logic [31:0] imm);
    exp_t   e;
    longint sx, sy, wide;
    int     iy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    iy = $signed(y);
    e.op = ref_decode(a, f);
    e.ov = 1'b0;
    e.res = 32'd0;
    case (e.op)
      5'd0:  e.res = x & y;
      5'd1:  e.res = x | y;
      5'd2:  begin wide = sx + sy; e.res = wide[31:0]; e.ov = (wide > MAX_S) || (wide < MIN_S); end
      5'd3:  e.res = x + y;
      5'd4:  begin wide = sx - sy; e.res = wide[31:0]; e.ov = (wide > MAX_S) || (wide < MIN_S); end
      5'd5:  e.res = x - y;
      5'd6:  e.res = x ^ y;
      5'd7:  e.res = ~(x | y);
      5'd8:  e.res = (sx < sy) ? 32'd1 : 32'd0;
      5'd9:  e.res = (x < y) ? 32'd1 : 32'd0;
      5'd10: e.res = y << s;
      5'd11: e.res = y >> s;
      5'd12: e.res = iy >>> s;
      5'd13: e.res = y << (x % 32);
      5'd14: e.res = y >> (x % 32);
      5'd15: e.res = iy >>> (x % 32);
      5'd16: e.res = y * 32'h0001_0000;
      default: e.res = 32'd0;
    endcase
    e.z  = (e.res == 32'd0);
    e.br = pc + imm * 32'd4;
    return e;
  endfunction

  task automatic drive(input logic e, input logic [3:0] a, input logic [5:0] f,
                       input logic [4:0] s, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] pc, input logic [31:0] imm);
    en = e; alu_op = a; func = f; shamt = s;
    op1 = x; op2 = y; pc_plus4 = pc; ext_imm = imm;
  endtask

  // One clock: update the expectation for the edge, then sample 1 ns later.
  task automatic cycle();
    exp_t nxt;
    nxt = ref_model(alu_op, func, shamt, op1, op2, pc_plus4, ext_imm);
    @(posedge clk);
    if (!rst_n) begin
      exp_q.res = 32'd0; exp_q.z = 1'b0; exp_q.ov = 1'b0; exp_q.br = 32'd0;
    end else if (en) begin
      exp_q = nxt;
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b1, 4'd1, 6'h20, 5'd3, 32'hDEAD_BEEF, 32'h1234_5678, 32'h400, 32'h10);
    cycle();
    drive(1'b1, 4'd0, 6'h22, 5'd7, 32'h5, 32'h5, 32'h800, 32'hFFFF_FFFF);
    cycle();
    total++; if (result !== 32'd0) begin bad++; $display("FAIL reset_result got=%h want=0", result); end
    total++; if (zero !== 1'b0) begin bad++; $display("FAIL reset_zero got=%b want=0", zero); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%b want=0", overflow); end
    total++; if (branch_addr !== 32'd0) begin bad++; $display("FAIL reset_branch got=%h want=0", branch_addr); end
    rst_n = 1'b1;
    drive(1'b1, 4'b0001, 6'h00, 5'd0, 32'd4, 32'd16, 32'd0, 32'd0);
    #1;
    total++; if (operation !== 5'd2) begin bad++; $display("FAIL first_op got=%0d want=2", operation); end
    cycle();
    total++; if (result !== 32'd20) begin bad++; $display("FAIL first_result got=%0d want=20", result); end
    total++; if (zero !== 1'b0) begin bad++; $display("FAIL first_zero got=%b want=0", zero); end
  endtask

  task automatic test_rtype_arith();
    drive(1'b1, 4'd0, 6'b100010, 5'd0, 32'd7, 32'd7, 32'd0, 32'd0);
    cycle();
    total++; if (result !== 32'd0 || zero !== 1'b1) begin bad++; $display("FAIL sub_zero got=%h/%b want=0/1", result, zero); end
    drive(1'b1, 4'd0, 6'b100000, 5'd0, 32'h7FFF_FFFF, 32'd1, 32'd0, 32'd0);
    cycle();
    total++; if (result !== 32'h8000_0000) begin bad++; $display("FAIL add_ovf_result got=%h want=80000000", result); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL add_ovf_flag got=%b want=1", overflow); end
    drive(1'b1, 4'd0, 6'b100001, 5'd0, 32'h7FFF_FFFF, 32'd1, 32'd0, 32'd0);
    cycle();
    total++; if (overflow !== 1'b0 || result !== 32'h8000_0000) begin bad++; $display("FAIL addu_no_ovf got=%h/%b want=80000000/0", result, overflow); end
    drive(1'b1, 4'd0, 6'b100010, 5'd0, 32'h8000_0000, 32'd1, 32'd0, 32'd0);
    cycle();
    total++; if (overflow !== 1'b1 || result !== 32'h7FFF_FFFF) begin bad++; $display("FAIL sub_ovf got=%h/%b want=7fffffff/1", result, overflow); end
  endtask

  task automatic test_cmp_shift();
    drive(1'b1, 4'd0, 6'b101010, 5'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0);
    cycle();
    total++; if (result !== 32'd1) begin bad++; $display("FAIL slt got=%h want=1", result); end
    drive(1'b1, 4'd0, 6'b101011, 5'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0);
    cycle();
    total++; if (result !== 32'd0 || zero !== 1'b1) begin bad++; $display("FAIL sltu got=%h/%b want=0/1", result, zero); end
    drive(1'b1, 4'd0, 6'b000011, 5'd4, 32'd0, 32'h8000_0000, 32'd0, 32'd0);
    cycle();
    total++; if (result !== 32'hF800_0000) begin bad++; $display("FAIL sra got=%h want=f8000000", result); end
    drive(1'b1, 4'd0, 6'b000100, 5'd0, 32'd33, 32'd1, 32'd0, 32'd0);
    cycle();
    total++; if (result !== 32'd2) begin bad++; $display("FAIL sllv got=%h want=2", result); end
  endtask

  task automatic test_branch();
    drive(1'b1, 4'd3, 6'd0, 5'd0, 32'd0, 32'd0, 32'd120, 32'hFFFF_FFFE);
    cycle();
    total++; if (branch_addr !== 32'd112) begin bad++; $display("FAIL branch_neg got=%0d want=112", branch_addr); end
    drive(1'b1, 4'd3, 6'd0, 5'd0, 32'd0, 32'd0, 32'hFFFF_FFFC, 32'd1);
    cycle();
    total++; if (branch_addr !== 32'd0) begin bad++; $display("FAIL branch_wrap got=%h want=0", branch_addr); end
  endtask

  task automatic test_hold();
    drive(1'b1, 4'd1, 6'd0, 5'd0, 32'd5, 32'd6, 32'd100, 32'd1);
    cycle();
    drive(1'b0, 4'd0, 6'b100010, 5'd9, 32'd3, 32'd3, 32'd500, 32'd77);
    cycle();
    drive(1'b0, 4'd0, 6'b100000, 5'd1, 32'h7FFF_FFFF, 32'd1, 32'd8, 32'd8);
    cycle();
    total++; if (result !== 32'd11) begin bad++; $display("FAIL hold_result got=%0d want=11", result); end
    total++; if (zero !== 1'b0 || overflow !== 1'b0) begin bad++; $display("FAIL hold_flags got=%b%b want=00", zero, overflow); end
    total++; if (branch_addr !== 32'd104) begin bad++; $display("FAIL hold_branch got=%0d want=104", branch_addr); end
  endtask

  task automatic test_invalid_decode();
    drive(1'b1, 4'b0000, 6'b111111, 5'd0, 32'h1234, 32'h5678, 32'd0, 32'd0);
    #1;
    total++; if (operation !== 5'd31) begin bad++; $display("FAIL nop_op got=%0d want=31", operation); end
    cycle();
    total++; if (result !== 32'd0 || zero !== 1'b1 || overflow !== 1'b0) begin bad++; $display("FAIL nop_out got=%h/%b/%b want=0/1/0", result, zero, overflow); end
    drive(1'b1, 4'b1111, 6'b100010, 5'd0, 32'd1, 32'd2, 32'd0, 32'd0);
    #1;
    total++; if (operation !== 5'd3) begin bad++; $display("FAIL addu_default_op got=%0d want=3", operation); end
  endtask

  task automatic test_lui_imm();
    drive(1'b1, 4'b1000, 6'd0, 5'd0, 32'd0, 32'h0000_1234, 32'd0, 32'd0);
    cycle();
    total++; if (result !== 32'h1234_0000) begin bad++; $display("FAIL lui got=%h want=12340000", result); end
    drive(1'b1, 4'b0100, 6'd0, 5'd0, 32'h0000_00F0, 32'h0000_000F, 32'd0, 32'd0);
    cycle();
    total++; if (result !== 32'h0000_00FF) begin bad++; $display("FAIL ori got=%h want=ff", result); end
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'h7FFF_FFFF;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'd0;
      default: return $urandom;
    endcase
  endfunction

  // Back-to-back random traffic with random enable and occasional reset.
  task automatic test_random();
    logic [5:0] valid_funcs [16];
    logic [5:0] f;
    valid_funcs = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                    6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07};
    for (int i = 0; i < 400; i++) begin
      f = ($urandom_range(0, 7) == 0) ? 6'($urandom) : valid_funcs[$urandom_range(0, 15)];
      rst_n = ($urandom_range(0, 39) != 0);
      drive(($urandom_range(0, 3) != 0), 4'($urandom), f, 5'($urandom),
            pick_operand(), pick_operand(), $urandom, $urandom);
      #1;
      total++;
      if (operation !== ref_decode(alu_op, func)) begin
        bad++; $display("FAIL rand_op[%0d] got=%0d want=%0d", i, operation, ref_decode(alu_op, func));
      end
      cycle();
      total++;
      if (result !== exp_q.res || zero !== exp_q.z || overflow !== exp_q.ov || branch_addr !== exp_q.br) begin
        bad++;
        $display("FAIL rand_out[%0d] got=%h/%b/%b/%h want=%h/%b/%b/%h", i,
                 result, zero, overflow, branch_addr, exp_q.res, exp_q.z, exp_q.ov, exp_q.br);
      end
    end
    rst_n = 1'b1;
  endtask

  initial begin
    exp_q = '0;
    rst_n = 1'b0;
    drive(1'b0, 4'd0, 6'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    test_reset();
    test_rtype_arith();
    test_cmp_shift();
    test_branch();
    test_hold();
    test_invalid_decode();
    test_lui_imm();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/exe_alu_unit.md
Name: exe_alu_unit

Overview:
- Execute-stage compute block of the 5-stage MIPS pipeline.
- Contains three functions:
  - ALU-control decode: (ALUop, func) → 5-bit operation.
  - 32-bit integer ALU with zero and overflow flags.
  - Branch-target adder.
- Sits between the forwarding muxes (which supply op1/op2) and the EXE/MEM register. All outputs are registered here so the EXE/MEM register can capture them directly.

Parameters:
- WIDTH, 32, datapath width; the only supported value is 32.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- en  in  1  capture enable; 0 holds all outputs.
- alu_op  in  4  ALUop from the control unit.
- func  in  6  instruction func field.
- shamt  in  5  instruction shift amount.
- op1  in  32  forwarded operand 1 (Rs).
- op2  in  32  forwarded operand 2 (Rt or extended immediate).
- pc_plus4  in  32  PC+4 of the instruction.
- ext_imm  in  32  sign- or zero-extended immediate.
- operation  out  5  decoded ALU operation; combinational.
- result  out  32  registered ALU result.
- zero  out  1  registered; 1 when the result is 0.
- overflow  out  1  registered signed-overflow flag.
- branch_addr  out  32  registered branch target.

Behaviour:
- Reset: on a clk edge with rst_n=0, result, zero, overflow and branch_addr all go to 0. Reset wins over en.
- Capture: on a clk edge with rst_n=1 and en=1, all registered outputs load their combinational values. Latency is 1 cycle. With en=0, outputs hold.
- Operation codes:
  - 0 AND, 1 OR, 2 ADD, 3 ADDU, 4 SUB, 5 SUBU, 6 XOR, 7 NOR
  - 8 SLT, 9 SLTU, 10 SLL, 11 SRL, 12 SRA, 13 SLLV, 14 SRLV, 15 SRAV
  - 16 LUI, 31 NOP
- ALUop decode:
  - 0000 selects R-type: decode func.
  - 0001 ADD (lw/sw/addi); 0010 SUB (beq/bne); 0011 AND; 0100 OR; 0101 XOR; 0110 SLT; 0111 SLTU; 1000 LUI.
  - Any other value gives ADDU.
- func decode (R-type):
  - 100000 ADD, 100001 ADDU, 100010 SUB, 100011 SUBU
  - 100100 AND, 100101 OR, 100110 XOR, 100111 NOR
  - 101010 SLT, 101011 SLTU
  - 000000 SLL, 000010 SRL, 000011 SRA, 000100 SLLV, 000110 SRLV, 000111 SRAV
  - Any other value gives NOP.
- Arithmetic: all modulo 2^32.
  - ADD/ADDU compute op1+op2; SUB/SUBU compute op1-op2.
- Overflow flag:
  - ADD: 1 when op1 and op2 have the same sign and the result sign differs.
  - SUB: 1 when op1 and op2 signs differ and the result sign differs from op1.
  - All other operations, including ADDU and SUBU: 0.
  - The result is written regardless of overflow; no trap is raised.
- Compares: SLT is a signed compare, SLTU unsigned; result is 32'd1 or 32'd0.
- Shifts:
  - SLL/SRL/SRA shift op2 by shamt.
  - SLLV/SRLV/SRAV shift op2 by op1[4:0].
  - SRA/SRAV replicate op2[31].
- LUI: result = {op2[15:0], 16'h0000}.
- NOP: result = 0, overflow = 0, so zero = 1.
- zero is computed from the final 32-bit result of the same cycle.
- branch_addr = pc_plus4 + (ext_imm << 2), modulo 2^32, independent of operation.
- operation is purely combinational from alu_op and func; it is not reset.

Test Plan:
- Reset: rst_n=0 for 2 cycles with arbitrary inputs → result=0, zero=0, overflow=0, branch_addr=0. Then en=1, alu_op=0001, op1=4, op2=16 → next cycle result=20, zero=0.
- R-type arithmetic:
  - func=100010, op1=op2=7 → result=0, zero=1.
  - func=100000, op1=32'h7FFFFFFF, op2=1 → result=32'h80000000, overflow=1.
  - Same operands with func=100001 → overflow=0.
- Compare and shifts:
  - SLT with op1=-1, op2=1 → result=1; SLTU with the same operands → result=0.
  - SRA with op2=32'h80000000, shamt=4 → result=32'hF8000000.
  - SLLV with op1=33, op2=1 → result=2.
- Branch target: pc_plus4=120, ext_imm=32'hFFFFFFFE → branch_addr=112. pc_plus4=32'hFFFFFFFC, ext_imm=1 → branch_addr=0 (wrap-around).
- Hold and invalid decode:
  - en=0 while inputs change → all outputs hold their previous values.
  - alu_op=0000, func=111111 → operation=31, result=0, zero=1.
  - alu_op=1111 → operation=3 (ADDU).
- LUI / immediate ops: alu_op=1000, op2=32'h00001234 → result=32'h12340000. alu_op=0100, op1=32'hF0, op2=32'h0F → result=32'hFF.
